// File: rtl/rcs_16b_seq_pkg.sv
// Shared definitions for the sequential ripple-borrow subtractor.
// State encoding and default geometry.
package rcs_16b_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_D = 16;
  localparam int SLICE_D = 4;
  localparam int N_D     = WIDTH_D / SLICE_D;
  localparam int CNT_W_D = $clog2(N_D);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Shared with the ripple carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rcs_16b_seq_slice.sv
// SLICE-bit ripple chunk: a + ~b + cin.
// Subtraction via full adders with the b input inverted.
module rcs_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[SLICE];

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

endmodule

// File: rtl/rcs_16b_seq.sv
// Multi-cycle ripple-borrow subtractor, D = A - B - Bin.
// One SLICE-bit chunk per CALC cycle, valid/ready on both sides.
module rcs_16b_seq
  import rcs_16b_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int SLICE = SLICE_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_bout;
  logic             r_v;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [IW-1:0]    w_base;
  logic [SLICE-1:0] w_s;
  logic             w_co;

  assign w_base = IW'(r_cnt) * IW'(SLICE);

  rcs_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[w_base +: SLICE]),
    .b    (r_b[w_base +: SLICE]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_bout      <= 1'b0;
      r_v         <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_c        <= ~Bin;
            r_cnt      <= '0;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
          end
        end
        CALC: begin
          r_d[w_base +: SLICE] <= w_s;
          r_c                  <= w_co;
          if (r_cnt == CW'(N - 1)) begin
            r_cnt       <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_bout      <= ~w_co;
            // w_s holds the MSB chunk of the completed difference
            r_v <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                   (w_s[SLICE-1] != r_a[WIDTH-1]);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign Bout      = r_bout;
  assign V         = r_v;

endmodule

// File: tb/tb_rcs_16b_seq.sv
// Self-checking bench for rcs_16b_seq: directed vectors,
// handshake/reset scenarios and a random run against an arithmetic model.
module tb_rcs_16b_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        Bout;
  logic        V;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [17:0] exp_q[$];
  int          acc_q[$];
  bit          busy = 0;
  int          k    = 0;

  rcs_16b_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {V, Bout, D} from plain 17-bit arithmetic
  function automatic logic [17:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic bi);
    logic [16:0] t;
    logic        v;
    t = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    v = (a[15] != b[15]) && (t[15] != a[15]);
    return {v, t[16], t[15:0]};
  endfunction

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy = 0;
      k    = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_result", {14'd0, V, Bout, D}, 32'd0);
    end else begin
      if (busy) k++;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, busy && k > N});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL result: out_valid with no pending op, got %h",
                   {V, Bout, D});
        end else begin
          chk("result", {14'd0, V, Bout, D}, {14'd0, exp_q[0]});
        end
      end
      if (busy && out_valid && out_ready) begin
        void'(exp_q.pop_front());
        busy = 0;
      end else if (!busy && in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Bin));
        acc_q.push_back(cyc);
        busy = 1;
        k    = 0;
      end
    end
  end

  // present operands, wait for acceptance; returns 0 on timeout
  task automatic accept(input logic [15:0] a, input logic [15:0] b,
                        input logic bi, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    A = a; B = b; Bin = bi; in_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Bin = $urandom_range(0, 1);
    if (!ok) begin
      n_assert++; n_fail++;
      $display("FAIL accept_timeout: in_ready never seen, expected 1");
    end
  endtask

  task automatic dir_op(input string nm, input logic [15:0] a,
                        input logic [15:0] b, input logic bi,
                        input logic [15:0] ed, input logic eb,
                        input logic ev);
    bit ok;
    int lat;
    out_ready = 1'b1;
    accept(a, b, bi, ok);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_lat"}, lat, N + 1);
    chk({nm, "_D"}, {16'd0, D}, {16'd0, ed});
    chk({nm, "_Bout"}, {31'd0, Bout}, {31'd0, eb});
    chk({nm, "_V"}, {31'd0, V}, {31'd0, ev});
    @(posedge clk); #1;
  endtask

  task automatic rand_op();
    bit ok;
    bit done;
    accept(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ok);
    done = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin done = 1; break; end
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
    if (!done) begin
      n_assert++; n_fail++;
      $display("FAIL rand_timeout: no output handshake, expected one");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    logic [17:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_basic", {14'd0, model(16'h0005, 16'h0003, 1'b0)},
        32'h0000_0002);
    chk("model_ovf", {14'd0, model(16'h7FFF, 16'hFFFF, 1'b0)},
        32'h0003_8000);

    dir_op("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    dir_op("wrap",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    dir_op("bin",   16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    dir_op("ovf1",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    dir_op("ovf2",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // backpressure with in_valid held high the whole time
    out_ready = 1'b0;
    accept(16'hA5A5, 16'h0F0F, 1'b1, ok);
    A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    held = {V, Bout, D};
    chk("bp_value", {14'd0, held}, 32'h0000_9695);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_hold", {14'd0, V, Bout, D}, {14'd0, held});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // back-to-back accepts
    acc_q.delete();
    A = 16'h0100; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (acc_q.size() >= 4) break;
    end
    in_valid = 1'b0;
    chk("b2b_count", acc_q.size() >= 4, 32'd1);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], N + 2);
    repeat (10) @(posedge clk);
    #1;

    // asynchronous reset in the middle of CALC
    accept(16'hFFFF, 16'h0001, 1'b0, ok);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_D", {16'd0, D}, 32'd0);
    chk("arst_flags", {30'd0, Bout, V}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    dir_op("post_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) rand_op();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
